store_unit: RTL and testbench

- Store-side counterpart of the load writeback path.
- Takes store requests from the MEM stage: byte address, rs2 data and mem_mode.
- Aligns the data into 32-bit byte lanes and generates the byte-enable strobe.
- Queues each aligned store in a small store buffer and drains it to data memory over a valid/ready handshake. The pipeline stalls only when the buffer is full.

---
 rtl/store_unit_pkg.sv | 42 ++++
 rtl/store_unit_if.sv | 26 ++
 rtl/store_unit_align.sv | 44 ++++
 rtl/store_unit.sv | 131 +++++++++++++
 tb/tb_store_unit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_unit_pkg.sv
// Shared store-path definitions: memory mode codes, bus widths and the
// store-buffer entry layout used by store_unit and store_align.
// Optional feature macro used by the store unit: SB_LD_HAZARD_EN.
`ifndef MEM_BYTE
`define MEM_BYTE        3'd0
`endif
`ifndef MEM_HWORD
`define MEM_HWORD       3'd1
`endif
`ifndef MEM_WORD
`define MEM_WORD        3'd2
`endif
`ifndef MEM_MODE_WIDTH
`define MEM_MODE_WIDTH  3
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH      32
`endif
`ifndef MEM_STRB_WIDTH
`define MEM_STRB_WIDTH  4
`endif

package store_unit_pkg;

    localparam int unsigned DATA_W = `DATA_WIDTH;
    localparam int unsigned MODE_W = `MEM_MODE_WIDTH;
    localparam int unsigned STRB_W = `MEM_STRB_WIDTH;

    typedef logic [MODE_W-1:0] mem_mode_t;

    localparam mem_mode_t MODE_BYTE  = `MEM_BYTE;
    localparam mem_mode_t MODE_HWORD = `MEM_HWORD;
    localparam mem_mode_t MODE_WORD  = `MEM_WORD;

    // One buffered, already lane-aligned store.
    typedef struct packed {
        logic [DATA_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } sb_entry_t;

endpackage

// File: rtl/store_unit_if.sv
// Data-memory write channel (valid/ready) driven by the store buffer.
interface store_unit_if;
    import store_unit_pkg::*;

    logic              mem_wvalid;
    logic              mem_wready;
    logic [DATA_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;

    modport master (
        output mem_wvalid,
        output mem_waddr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_wready
    );

    modport slave (
        input  mem_wvalid,
        input  mem_waddr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_wready
    );
endinterface

// File: rtl/store_unit_align.sv
// store_align: combinational byte-lane alignment and strobe generation.
// misalign covers both bad offsets and illegal mode codes.
module store_align
    import store_unit_pkg::*;
(
    input  mem_mode_t         mode,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              misalign
);

    // Replicate the store operand across lanes and pick the enabled bytes.
    always_comb begin
        wdata    = '0;
        wstrb    = '0;
        misalign = 1'b0;
        case (mode)
            MODE_BYTE: begin
                wdata = {4{data[7:0]}};
                wstrb = STRB_W'(4'b0001) << off;
            end
            MODE_HWORD: begin
                wdata = {2{data[15:0]}};
                if (off[0]) begin
                    misalign = 1'b1;
                end else begin
                    wstrb = off[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
                end
            end
            MODE_WORD: begin
                wdata = data;
                if (off != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    wstrb = '1;
                end
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// store_unit: aligns MEM-stage stores, queues them in a small FIFO store
// buffer and drains it to data memory over a valid/ready channel.
// Optional macro SB_LD_HAZARD_EN builds the load/store address comparators.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 2,
    parameter int unsigned SB_CNT_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [DATA_W-1:0]   st_addr,
    input  logic [DATA_W-1:0]   st_data,
    input  mem_mode_t           st_mode,
    output logic                st_fault,
    store_unit_if.master        mem,
    output logic [SB_CNT_W-1:0] sb_count,
    output logic                sb_empty,
    input  logic [DATA_W-1:0]   ld_addr,
    input  logic                ld_valid,
    output logic                ld_hazard
);

    localparam int unsigned PTR_W = $clog2(SB_DEPTH);

    if (SB_DEPTH < 2 || (SB_DEPTH & (SB_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("store_unit: SB_DEPTH must be a power of two >= 2");
    end
    if (SB_CNT_W != $clog2(SB_DEPTH) + 1) begin : g_bad_cnt_w
        $error("store_unit: SB_CNT_W must equal clog2(SB_DEPTH)+1");
    end

    sb_entry_t           entries [SB_DEPTH];
    logic [SB_DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [SB_CNT_W-1:0] count;

    logic [DATA_W-1:0]   al_wdata;
    logic [STRB_W-1:0]   al_wstrb;
    logic                al_misalign;
    logic                accept;
    logic                enq;
    logic                deq;
    logic                head_valid;

    store_align u_align (
        .mode     (st_mode),
        .off      (st_addr[1:0]),
        .data     (st_data),
        .wdata    (al_wdata),
        .wstrb    (al_wstrb),
        .misalign (al_misalign)
    );

    // Handshake decode; no full-bypass, st_ready looks only at the count.
    assign st_ready   = (count < SB_CNT_W'(SB_DEPTH));
    assign accept     = st_valid && st_ready;
    assign enq        = accept && !al_misalign;
    assign head_valid = ent_valid[head];
    assign deq        = head_valid && mem.mem_wready;

    // Head entry drives the memory channel; gated so an empty buffer shows zeros.
    assign mem.mem_wvalid = head_valid;
    assign mem.mem_waddr  = head_valid ? entries[head].waddr : '0;
    assign mem.mem_wdata  = head_valid ? entries[head].wdata : '0;
    assign mem.mem_wstrb  = head_valid ? entries[head].wstrb : '0;

    assign sb_count = count;
    assign sb_empty = (count == '0);

    // Pointers, occupancy, valid bits and the fault pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            st_fault  <= 1'b0;
        end else begin
            st_fault <= accept && al_misalign;
            if (enq) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            if (deq) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + SB_CNT_W'(1);
                2'b01:   count <= count - SB_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; contents are qualified by ent_valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[tail] <= '{waddr: {st_addr[DATA_W-1:2], 2'b00},
                               wdata: al_wdata,
                               wstrb: al_wstrb};
        end
    end

`ifdef SB_LD_HAZARD_EN
    logic hit;
    logic unused_ld_off;
    assign unused_ld_off = ^ld_addr[1:0];

    // A load hits when any buffered store targets the same word.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(SB_DEPTH); i++) begin
            if (ent_valid[i] && entries[i].waddr[DATA_W-1:2] == ld_addr[DATA_W-1:2]) begin
                hit = 1'b1;
            end
        end
    end

    assign ld_hazard = ld_valid && hit;
`else
    logic unused_ld;
    assign unused_ld = ^{ld_valid, ld_addr};
    assign ld_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed stores, scoreboard monitor on
// the data-memory write channel.
module tb_store_unit;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_mode;
    logic        st_fault;
    logic [1:0]  sb_count;
    logic        sb_empty;
    logic [31:0] ld_addr;
    logic        ld_valid;
    logic        ld_hazard;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t exp_q[$];

    localparam logic [2:0] SB = 3'd0;
    localparam logic [2:0] SH = 3'd1;
    localparam logic [2:0] SW = 3'd2;

    store_unit_if mem_if ();

    store_unit #(.SB_DEPTH(2), .SB_CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_mode   (st_mode),
        .st_fault  (st_fault),
        .mem       (mem_if),
        .sb_count  (sb_count),
        .sb_empty  (sb_empty),
        .ld_addr   (ld_addr),
        .ld_valid  (ld_valid),
        .ld_hazard (ld_hazard)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Present one store, wait for acceptance, then check the fault pulse.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                         input logic f, input logic [31:0] ed, input logic [3:0] es);
        int n = 0;
        st_addr  = a;
        st_data  = d;
        st_mode  = m;
        st_valid = 1'b1;
        @(negedge clk);
        while (!st_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", 32'(st_ready), 32'd1);
        if (!f) exp_q.push_back('{a: a & 32'hFFFF_FFFC, d: ed, s: es});
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        chk("st_fault", 32'(st_fault), 32'(f));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every completed write must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_if.mem_wvalid && mem_if.mem_wready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", mem_if.mem_waddr, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("waddr", mem_if.mem_waddr, e.a);
                    chk("wdata", mem_if.mem_wdata, e.d);
                    chk("wstrb", 32'(mem_if.mem_wstrb), 32'(e.s));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        st_valid = 1'b0;
        st_addr = '0;
        st_data = '0;
        st_mode = SW;
        ld_addr = '0;
        ld_valid = 1'b0;
        mem_if.mem_wready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wvalid", 32'(mem_if.mem_wvalid), 32'd0);
        chk("rst_waddr", mem_if.mem_waddr, 32'd0);
        chk("rst_wdata", mem_if.mem_wdata, 32'd0);
        chk("rst_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
        chk("rst_fault", 32'(st_fault), 32'd0);
        chk("rst_count", 32'(sb_count), 32'd0);
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_hazard", 32'(ld_hazard), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Byte store at lane 3, one-cycle latency to mem_wvalid.
        mem_if.mem_wready = 1'b1;
        issue(32'h1003, 32'h0000_00A5, SB, 1'b0, 32'hA5A5_A5A5, 4'b1000);
        chk("latency_wvalid", 32'(mem_if.mem_wvalid), 32'd1);
        wait_drain();

        // Halfword upper lanes, then a misaligned halfword that must not enqueue.
        mem_if.mem_wready = 1'b0;
        issue(32'h2002, 32'h1234_BEEF, SH, 1'b0, 32'hBEEF_BEEF, 4'b1100);
        chk("sh_count", 32'(sb_count), 32'd1);
        issue(32'h2001, 32'h1234_BEEF, SH, 1'b1, 32'h0, 4'b0000);
        chk("fault_count", 32'(sb_count), 32'd1);
        @(posedge clk);
        #1;
        chk("fault_one_cycle", 32'(st_fault), 32'd0);
        mem_if.mem_wready = 1'b1;
        wait_drain();

        // Assorted lanes, modes and illegal encodings.
        issue(32'h0010, 32'h0000_01FF, SB, 1'b0, 32'hFFFF_FFFF, 4'b0001);
        issue(32'h0011, 32'hFFFF_FF37, SB, 1'b0, 32'h3737_3737, 4'b0010);
        issue(32'h0000, 32'h5555_CAFE, SH, 1'b0, 32'hCAFE_CAFE, 4'b0011);
        issue(32'h0044, 32'hDEAD_BEEF, SW, 1'b0, 32'hDEAD_BEEF, 4'b1111);
        issue(32'h0046, 32'hDEAD_BEEF, SW, 1'b1, 32'h0, 4'b0000);
        issue(32'h0003, 32'h0000_1234, SH, 1'b1, 32'h0, 4'b0000);
        issue(32'h0100, 32'h0000_0001, 3'd7, 1'b1, 32'h0, 4'b0000);
        issue(32'h0104, 32'h0000_0001, 3'd4, 1'b1, 32'h0, 4'b0000);
        issue(32'h0202, 32'h0000_00C3, SB, 1'b0, 32'hC3C3_C3C3, 4'b0100);
        wait_drain();

        // Backpressure: two accepts fill the buffer, outputs hold while stalled.
        mem_if.mem_wready = 1'b0;
        issue(32'h4000, 32'h1111_1111, SW, 1'b0, 32'h1111_1111, 4'b1111);
        issue(32'h4004, 32'h2222_2222, SW, 1'b0, 32'h2222_2222, 4'b1111);
        chk("full_ready", 32'(st_ready), 32'd0);
        chk("full_count", 32'(sb_count), 32'd2);
        st_addr = 32'h4008;
        st_data = 32'h3333_3333;
        st_mode = SW;
        st_valid = 1'b1;
        exp_q.push_back('{a: 32'h4008, d: 32'h3333_3333, s: 4'b1111});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_wvalid", 32'(mem_if.mem_wvalid), 32'd1);
            chk("stall_waddr", mem_if.mem_waddr, 32'h4000);
            chk("stall_wdata", mem_if.mem_wdata, 32'h1111_1111);
            chk("stall_ready", 32'(st_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        mem_if.mem_wready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!st_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("third_accept", 32'(st_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        wait_drain();

        // Full with wready high: dequeue does not bypass into st_ready.
        mem_if.mem_wready = 1'b0;
        issue(32'h5000, 32'hA0A0_0001, SW, 1'b0, 32'hA0A0_0001, 4'b1111);
        issue(32'h5004, 32'hA0A0_0002, SW, 1'b0, 32'hA0A0_0002, 4'b1111);
        mem_if.mem_wready = 1'b1;
        st_addr = 32'h5008;
        st_data = 32'hA0A0_0003;
        st_mode = SW;
        st_valid = 1'b1;
        exp_q.push_back('{a: 32'h5008, d: 32'hA0A0_0003, s: 4'b1111});
        @(negedge clk);
        chk("nobypass_ready", 32'(st_ready), 32'd0);
        chk("nobypass_count", 32'(sb_count), 32'd2);
        @(negedge clk);
        chk("after_deq_ready", 32'(st_ready), 32'd1);
        chk("after_deq_count", 32'(sb_count), 32'd1);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        chk("enq_deq_count", 32'(sb_count), 32'd1);
        wait_drain();

        // Reset while two stores are pending discards them.
        mem_if.mem_wready = 1'b0;
        issue(32'h6000, 32'h0BAD_0001, SW, 1'b0, 32'h0BAD_0001, 4'b1111);
        issue(32'h6004, 32'h0BAD_0002, SW, 1'b0, 32'h0BAD_0002, 4'b1111);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("mrst_empty", 32'(sb_empty), 32'd1);
        chk("mrst_wvalid", 32'(mem_if.mem_wvalid), 32'd0);
        chk("mrst_waddr", mem_if.mem_waddr, 32'd0);
        chk("mrst_wdata", mem_if.mem_wdata, 32'd0);
        chk("mrst_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
        chk("mrst_count", 32'(sb_count), 32'd0);
        chk("mrst_ready", 32'(st_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load hazard against buffered store words.
        issue(32'h3004, 32'h7777_7777, SW, 1'b0, 32'h7777_7777, 4'b1111);
        ld_valid = 1'b1;
        ld_addr = 32'h3006;
        #1;
`ifdef SB_LD_HAZARD_EN
        chk("hazard_hit", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h3008;
        #1;
        chk("hazard_miss", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h3004;
        ld_valid = 1'b0;
        #1;
        chk("hazard_noload", 32'(ld_hazard), 32'd0);
`else
        chk("hazard_tied", 32'(ld_hazard), 32'd0);
`endif
        ld_valid = 1'b0;
        mem_if.mem_wready = 1'b1;
        wait_drain();
        chk("final_empty", 32'(sb_empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
